// File: rtl/pattern_scan_pkg.sv
// rtl/pattern_scan_pkg.sv - shared state encodings and width helper for the pattern scanner
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    function automatic int cnt_width(input int word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// rtl/pattern_match_core.sv - serial history register, fill counter and masked pattern compare
module pattern_match_core #(
    parameter int PAT_MAX = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bit_valid,
    input  logic               bit_in,
    input  logic               clr,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               match
);

    localparam int FILL_W = $clog2(PAT_MAX + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_MAX);

    logic [PAT_MAX-1:0] hist_q;
    logic [PAT_MAX-1:0] hist_new;
    logic [PAT_MAX-1:0] mask;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_inc;
    logic [FILL_W-1:0]  len_eff;

    always_comb begin
        len_eff = FILL_W'(len);
        if (32'(len) > PAT_MAX) begin
            len_eff = FILL_MAX;
        end
        hist_new = {hist_q[PAT_MAX-2:0], bit_in};
        fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < int'(len_eff));
        end
        // fill counts bits since the last clear, so a match never uses stale history
        match = bit_valid && (len_eff != '0) && (fill_inc >= len_eff)
                && (((hist_new ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (bit_valid) begin
            hist_q <= hist_new;
            fill_q <= (match && !overlap) ? '0 : fill_inc;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - word-to-bit sequencer feeding the match core, one result per word
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int WORD_W  = 8,
    parameter int PAT_MAX = 8,
    localparam int CNT_W  = cnt_width(WORD_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   out_count,
    output logic [CNT_W-1:0]   out_first,
    output logic               out_hit
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] NO_MATCH = CNT_W'(WORD_W);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                last_q, last_d;
    logic [PAT_MAX-1:0]  pat_q, pat_d;
    logic [3:0]          len_q, len_d;
    logic                ovl_q, ovl_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    first_q, first_d;
    logic                bit_valid;
    logic                core_clr;
    logic                match;

    pattern_match_core #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (4)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .bit_in    (word_q[WORD_W-1]),
        .clr       (core_clr),
        .pattern   (pat_q),
        .len       (len_q),
        .overlap   (ovl_q),
        .match     (match)
    );

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        last_d    = last_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        idx_d     = idx_q;
        count_d   = count_q;
        first_d   = first_q;
        in_ready  = 1'b0;
        bit_valid = 1'b0;
        core_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    word_d  = in_data;
                    last_d  = in_last;
                    pat_d   = cfg_pattern;
                    len_d   = cfg_len;
                    ovl_d   = cfg_overlap;
                    idx_d   = '0;
                    count_d = '0;
                    first_d = NO_MATCH;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bit_valid = 1'b1;
                word_d    = {word_q[WORD_W-2:0], 1'b0};
                idx_d     = idx_q + CNT_W'(1);
                if (match) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_q == '0) begin
                        first_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (out_ready) begin
                    core_clr = last_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            last_q  <= 1'b0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            idx_q   <= '0;
            count_q <= '0;
            first_q <= NO_MATCH;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            last_q  <= last_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            first_q <= first_d;
        end
    end

    assign out_valid = (state_q == ST_REPORT);
    assign out_count = count_q;
    assign out_first = first_q;
    assign out_hit   = (count_q != '0);

endmodule
